muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage of the RV32I pipelined core. It sits beside the ALU and takes the same forwarded op1/op2. Its result is merged with ALU_out in front of the EX/MEM register. It handles the eight M-extension operations over multiple cycles and tells the hazard unit to stall the front of the pipeline until the result is ready.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX holds an M-extension instruction; request an operation.
- md_func  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  input  32  rs1 operand, after forwarding.
- op2  input  32  rs2 operand, after forwarding.
- flush  input  1  EX flush (branch/jump redirect); aborts any operation in progress.
- busy  output  1  an operation is in progress; the hazard unit stalls IF/ID/EX while busy is 1.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  operation result; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch md_func, latch operand magnitudes and result sign, load the 6-bit iteration counter with 32, go to CALC.
- CALC:
  - One iteration per cycle; the counter decrements.
  - Multiply: radix-2 shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract on a 64-bit remainder/quotient register.
  - When the counter reaches 1: apply the sign fix, select the 32-bit field, register it into result, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1: begin a new operation, go to CALC (back-to-back issue).
  - start=0: go to IDLE.
- start is ignored while in CALC.
- flush=1 in any state: go to IDLE on the next edge; done is not raised; result is not updated. flush has priority over a simultaneous start.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Result field:
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - The remainder takes the sign of the dividend.
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = op1.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Both cases still take the full latency, so latency is always deterministic.
- Arithmetic widths:
  - Magnitudes are 32-bit unsigned; |0x80000000| is represented as 0x80000000 unsigned.
  - Negation is two's complement over 64 bits (product) or 32 bits (quotient/remainder).

## Timing
- Reset values: busy=0, done=0, result=0x00000000; state=IDLE; all internal registers 0.
- Reset mid-operation clears the unit immediately (asynchronous); there is no done.
- Let cycle 0 be the edge where start is sampled. Iterative latency:
  - CALC occupies cycles 1..32 and busy=1 in those cycles.
  - DONE is cycle 33: done=1, busy=0, result valid.
- The hazard unit stalls while (start & ~done); the instruction leaves EX in the done cycle.
- Back-to-back: a start sampled in the DONE cycle puts the unit in CALC at cycle 34.
- Operands and md_func are sampled only at the accepting edge. Later changes on op1/op2 have no effect.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - The four multiply operations use a single-cycle combinational 33x33 signed multiplier.
  - start at cycle 0 goes IDLE to DONE directly: done=1 at cycle 1, busy stays 0.
  - Divides are unchanged (33-cycle latency).
- MULDIV_FAST_MUL_EN undefined: all eight operations use the iterative path with 33-cycle latency.

## Test plan
- MUL 0x00001234 × 0x00005678 -> result=0x06260060; done at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN); busy high in cycles 1..32.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF. REMU 7/0 -> 7. DIV 5/0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
- flush at cycle 10 of a DIV -> IDLE at cycle 11, no done pulse, result keeps its previous value. A start in the same cycle as the flush is dropped.
- rst_n pulsed low at cycle 15 of a MULHU -> busy, done and result are 0 immediately. A new DIVU 100/7 issued after release -> result 14 after the full latency; back-to-back REMU 100/7 issued in the done cycle -> 2.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the EX stage.
//            Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      md_func,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_ITER = 6'd32;

    state_t            r_state;
    logic [2:0]        r_func;
    logic [5:0]        r_cnt;
    logic [63:0]       r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_divz;
    logic [XLEN-1:0]   r_op1;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_op1_signed;
    logic              w_op2_signed;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [32:0]       w_add;
    logic [63:0]       w_mul_next;
    logic [32:0]       w_shl;
    logic              w_ge;
    logic [31:0]       w_sub;
    logic [63:0]       w_div_next;
    logic [63:0]       w_nacc;
    logic [63:0]       w_prod;
    logic [31:0]       w_quo;
    logic [31:0]       w_rem;
    logic [XLEN-1:0]   w_calc_res;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    // Operand decode for the incoming request
    assign w_op1_signed = !((md_func == 3'b011) || (md_func == 3'b101) || (md_func == 3'b111));
    assign w_op2_signed = (md_func == 3'b000) || (md_func == 3'b001) ||
                          (md_func == 3'b100) || (md_func == 3'b110);
    assign w_s1   = w_op1_signed & op1[XLEN-1];
    assign w_s2   = w_op2_signed & op2[XLEN-1];
    assign w_mag1 = w_s1 ? -op1 : op1;
    assign w_mag2 = w_s2 ? -op2 : op2;

    // Multiply step: r_acc = {partial product, remaining multiplier bits}
    assign w_add      = {1'b0, r_acc[63:32]} + {1'b0, r_mcand};
    assign w_mul_next = r_acc[0] ? {w_add, r_acc[31:1]} : (r_acc >> 1);

    // Divide step: r_acc = {partial remainder, dividend/quotient bits}
    assign w_shl      = r_acc[63:31];
    assign w_ge       = (w_shl >= {1'b0, r_mcand});
    assign w_sub      = w_shl[31:0] - r_mcand;
    assign w_div_next = w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

    assign w_nacc = r_func[2] ? w_div_next : w_mul_next;
    assign w_prod = r_neg_q ? -w_nacc : w_nacc;
    assign w_quo  = r_neg_q ? -w_nacc[31:0] : w_nacc[31:0];
    assign w_rem  = r_neg_r ? -w_nacc[63:32] : w_nacc[63:32];

    always_comb begin
        w_calc_res = '0;
        case (r_func)
            3'b000:                 w_calc_res = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_calc_res = w_prod[63:32];
            3'b100, 3'b101:         w_calc_res = r_divz ? '1 : w_quo;
            default:                w_calc_res = r_divz ? r_op1 : w_rem;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [32:0]        w_fa;
    logic [32:0]        w_fb;
    logic signed [63:0] w_fprod;

    assign w_fa       = {w_s1, op1};
    assign w_fb       = {w_s2, op2};
    assign w_fprod    = $signed(w_fa) * $signed(w_fb);
    assign w_fast     = !md_func[2];
    assign w_fast_res = (md_func == 3'b000) ? w_fprod[31:0] : w_fprod[63:32];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_func   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_op1    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (!start) begin
                        r_state <= S_IDLE;
                    end else if (w_fast) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_fast_res;
                    end else begin
                        // Multiplier sits in the low half; divisor/multiplicand in r_mcand
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_func  <= md_func;
                        r_cnt   <= c_ITER;
                        r_acc   <= {32'h0, (md_func[2] ? w_mag1 : w_mag2)};
                        r_mcand <= md_func[2] ? w_mag2 : w_mag1;
                        r_neg_q <= w_s1 ^ w_s2;
                        r_neg_r <= w_s1;
                        r_divz  <= (op2 == '0);
                        r_op1   <= op1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_nacc;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_calc_res;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Randomized self-checking bench for muldiv_unit against an
//            arithmetic reference model (honours MULDIV_FAST_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  md_func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_func (md_func),
        .op1     (op1),
        .op2     (op2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: RISC-V M semantics via 64-bit integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub_l;
        longint      q;
        logic [63:0] ua;
        logic [63:0] p;
        sa   = $signed(a);
        sb   = $signed(b);
        ub_l = {32'h0, b};
        ua   = {32'h0, a};
        case (f)
            3'd0: begin p = sa * sb;             return p[31:0];  end
            3'd1: begin p = sa * sb;             return p[63:32]; end
            3'd2: begin p = sa * ub_l;           return p[63:32]; end
            3'd3: begin p = ua * {32'h0, b};     return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        md_func = f;
        op1     = a;
        op2     = b;
    endtask

    // Called right after issue(); returns at the negedge of the done cycle
    task automatic finish_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input string tag);
        logic [31:0] exp;
        int          lat;
        int          n;
        int          busy_err;
        bit          seen;
        exp      = ref_op(f, a, b);
        lat      = (c_FAST && !f[2]) ? 1 : 33;
        n        = 0;
        busy_err = 0;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start   = 1'b0;
                op1     = $urandom;
                op2     = $urandom;
                md_func = 3'($urandom);
            end
            if (done) seen = 1'b1;
            if (busy !== (n < lat)) busy_err++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy"}, busy_err, 0);
        check({tag, " result"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int dcount;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        md_func = 3'd0;
        op1     = 32'h0;
        op2     = 32'h0;
        last_res = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset result", result, 32'h0);

        issue(3'd0, 32'h0000_1234, 32'h0000_5678); finish_op(3'd0, 32'h0000_1234, 32'h0000_5678, "mul");
        check("mul const", result, 32'h0626_0060);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000); finish_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
        check("mulh const", result, 32'h4000_0000);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        check("mulhsu const", result, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        check("mulhu const", result, 32'hFFFF_FFFE);
        issue(3'd4, 32'hFFFF_FFF9, 32'h2); finish_op(3'd4, 32'hFFFF_FFF9, 32'h2, "div");
        check("div const", result, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'h2); finish_op(3'd6, 32'hFFFF_FFF9, 32'h2, "rem");
        check("rem const", result, 32'hFFFF_FFFF);
        issue(3'd7, 32'h7, 32'h0); finish_op(3'd7, 32'h7, 32'h0, "remu0");
        check("remu0 const", result, 32'h7);
        issue(3'd4, 32'h5, 32'h0); finish_op(3'd4, 32'h5, 32'h0, "div0");
        check("div0 const", result, 32'hFFFF_FFFF);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); finish_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        check("divovf const", result, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF); finish_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "removf");
        check("removf const", result, 32'h0);
        issue(3'd5, 32'hFFFF_FFFE, 32'h2); finish_op(3'd5, 32'hFFFF_FFFE, 32'h2, "divu");
        check("divu const", result, 32'h7FFF_FFFF);

        // Flush in the middle of a divide, with a competing start
        issue(3'd4, 32'd100, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        flush = 1'b1;
        issue(3'd3, $urandom, $urandom);
        @(negedge clk);
        check("flush busy", {31'h0, busy}, 32'h0);
        check("flush done", {31'h0, done}, 32'h0);
        check("flush result", result, last_res);
        flush = 1'b0;
        start = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush no done", dcount, 0);
        check("flush held", result, last_res);

        // Asynchronous reset in the middle of a multiply
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("arst busy", {31'h0, busy}, 32'h0);
        check("arst done", {31'h0, done}, 32'h0);
        check("arst result", result, 32'h0);
        last_res = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd5, 32'd100, 32'd7); finish_op(3'd5, 32'd100, 32'd7, "divu after rst");
        check("divu100 const", result, 32'd14);
        issue(3'd7, 32'd100, 32'd7); finish_op(3'd7, 32'd100, 32'd7, "remu b2b");
        check("remu100 const", result, 32'd2);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check("done pulse width", {31'h0, done}, 32'h0);
            end
            issue(f, a, b);
            finish_op(f, a, b, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
